// File: rtl/fp_mul_result_collector.sv
// Credit-gated result FIFO behind a pipelined FP multiplier, with sticky flags.
// Ports: clk/rst (sync, active-low), issue_*, res_*, out_*, fflags, fflags_clr, overrun_err. Macro: FP_FLAG_ACCUM_EN.
module fp_mul_result_collector #(
  parameter int DEPTH    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic [3:0]  res_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags,
  output logic [3:0]  fflags,
  input  logic        fflags_clr,
  output logic        overrun_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int unused_pipe_lat = PIPE_LAT;

  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;

  logic issue_fire;
  logic deq_fire;
  logic full;
  logic wr_en;
  logic drop;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credits count both queued and in-flight results, so
  // a result can never arrive without a slot reserved.
  assign issue_ready =
    ({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);

  assign issue_fire = issue_valid & issue_ready;
  assign out_valid  = (count != '0);
  assign deq_fire   = out_valid & out_ready;
  assign full       = (count == CW'(DEPTH));
  // When full, wr_ptr == rd_ptr: a same-cycle pop frees
  // the very slot being written.
  assign wr_en      = res_valid & (~full | deq_fire);
  assign drop       = res_valid & full & ~deq_fire;

  assign {out_flags, out_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {res_flags, res_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr <= ptr_inc(wr_ptr);
      if (deq_fire) rd_ptr <= ptr_inc(rd_ptr);

      if (wr_en & ~deq_fire)
        count <= count + CW'(1);
      else if (deq_fire & ~wr_en)
        count <= count - CW'(1);

      // Stray results (e.g. after reset) saturate at 0.
      if (issue_fire & ~res_valid)
        inflight <= inflight + CW'(1);
      else if (res_valid & ~issue_fire & (inflight != '0))
        inflight <= inflight - CW'(1);

      if (drop) overrun_err <= 1'b1;
    end
  end

`ifdef FP_FLAG_ACCUM_EN
  logic [3:0] fflags_q;

  // Clear first, then OR in the committed entry, so a
  // pop in the clear cycle keeps its flags.
  always_ff @(posedge clk) begin
    if (!rst)
      fflags_q <= '0;
    else
      fflags_q <= (fflags_clr ? 4'b0000 : fflags_q)
                | (deq_fire ? out_flags : 4'b0000);
  end

  assign fflags = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr;
  assign fflags = 4'b0000;
`endif

endmodule
